rotate_arbiter: RTL and testbench

- Shares one WIDTH-bit rotate-right datapath between two requesters.
- Two valid/ready request ports are arbitrated round-robin. Each accepted word is rotated right by its own amount and the result is registered into a one-entry output buffer.
- The response carries the requester ID and is drained with a valid/ready handshake toward downstream logic.

---
 rtl/rotate_arbiter.sv | 86 ++++++++
 tb/tb_rotate_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rotate_arbiter.sv
// Two-port round-robin arbiter that feeds a shared rotate-right datapath and
// keeps the result in a single output register with a valid/ready handshake.
module rotate_arbiter #(
    parameter int WIDTH = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_amt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_amt,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_last_grant;
    logic [WIDTH-1:0]   r_data;
    logic               r_id;

    logic               w_can_accept;
    logic               w_gnt0, w_gnt1;
    logic               w_acc0, w_acc1, w_accept;
    logic [WIDTH-1:0]   w_sel_data;
    logic [SHW-1:0]     w_sel_amt;
    logic [2*WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0]   w_rot;

    // Contention goes to whoever did not win the last accepted transfer.
    assign w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);

    assign w_can_accept = (r_state == EMPTY) || rsp_ready;
    assign req0_ready   = !rst && w_can_accept && w_gnt0;
    assign req1_ready   = !rst && w_can_accept && w_gnt1;

    assign w_acc0   = req0_valid && req0_ready;
    assign w_acc1   = req1_valid && req1_ready;
    assign w_accept = w_acc0 || w_acc1;

    assign w_sel_data = w_acc1 ? req1_data : req0_data;
    assign w_sel_amt  = w_acc1 ? req1_amt  : req0_amt;

    // Shifting a doubled copy right leaves the rotated word in the low half.
    assign w_dbl = {w_sel_data, w_sel_data} >> w_sel_amt;
    assign w_rot = w_dbl[WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FULL;
            FULL:    if (rsp_ready && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_last_grant <= 1'b1;
            r_data       <= '0;
            r_id         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data       <= w_rot;
                r_id         <= w_acc1;
                r_last_grant <= w_acc1;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed bench for rotate_arbiter: rotation, round-robin order, stall,
// async reset and abandoned requests, with hand-computed expectations.
module tb_rotate_arbiter;

    localparam int WIDTH = 4;
    localparam int SHW   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic [SHW-1:0]   req0_amt, req1_amt;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_id, rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    rotate_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [WIDTH-1:0] d, input logic id);
        chk({tag, "_valid"}, rsp_valid, v);
        chk({tag, "_data"},  rsp_data,  d);
        chk({tag, "_id"},    rsp_id,    id);
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, "_rdy0"}, req0_ready, r0);
        chk({tag, "_rdy1"}, req1_ready, r1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 4'b1011; req0_amt = 2'd1;
        req1_valid = 1'b1; req1_data = 4'b1000; req1_amt = 2'd3;
        rsp_ready  = 1'b1;
        #2;
        // Reset state, requests held valid to show readies are masked
        chk_rsp("reset", 1'b0, 4'b0000, 1'b0);
        chk_rdy("reset", 1'b0, 1'b0);
        tick();
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;

        // Single requester, each rotate amount, back-to-back
        chk_rdy("r0_alone", 1'b1, 1'b0);
        tick();
        chk_rsp("rot1", 1'b1, 4'b1101, 1'b0);
        req0_amt = 2'd2; #1;
        chk_rdy("r0_refill", 1'b1, 1'b0);
        tick();
        chk_rsp("rot2", 1'b1, 4'b1110, 1'b0);
        req0_amt = 2'd3;
        tick();
        chk_rsp("rot3", 1'b1, 4'b0111, 1'b0);
        req0_amt = 2'd0;
        tick();
        chk_rsp("rot0", 1'b1, 4'b1011, 1'b0);

        // Both valid from reset: req0 first, then req1
        req0_valid = 1'b0;
        do_reset();
        req0_valid = 1'b1; req0_data = 4'b0001; req0_amt = 2'd1;
        req1_valid = 1'b1; req1_data = 4'b1000; req1_amt = 2'd3;
        #1;
        chk_rdy("both_c1", 1'b1, 1'b0);
        tick();
        chk_rsp("both_c1", 1'b1, 4'b1000, 1'b0);
        chk_rdy("both_c2", 1'b0, 1'b1);
        tick();
        chk_rsp("both_c2", 1'b1, 4'b0001, 1'b1);

        // Continuous contention: strict alternation, no bubbles
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_rsp($sformatf("rr%0d", i), 1'b1,
                    (i % 2 == 0) ? 4'b1000 : 4'b0001, 1'(i % 2));
        end

        // Stall with last result from req1 held; both valid
        rsp_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
            tick();
            chk_rsp($sformatf("stall%0d", i), 1'b1, 4'b0001, 1'b1);
        end
        rsp_ready = 1'b1;
        #1;
        chk_rdy("unstall", 1'b1, 1'b0);
        tick();
        chk_rsp("unstall", 1'b1, 4'b1000, 1'b0);

        // Async reset while FULL, req1 valid with a fresh command
        req0_valid = 1'b0;
        req1_data  = 4'b0110; req1_amt = 2'd1;
        rsp_ready  = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_rsp("async_rst", 1'b0, 4'b0000, 1'b0);
        chk_rdy("async_rst", 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk_rdy("post_rst", 1'b0, 1'b1);
        tick();
        chk_rsp("post_rst", 1'b1, 4'b0011, 1'b1);
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        chk("drain_empty", rsp_valid, 1'b0);

        // Abandoned req1 during a stall leaves last_grant at 0
        req0_valid = 1'b1; req0_data = 4'b0010; req0_amt = 2'd1;
        tick();
        chk_rsp("pre_stall", 1'b1, 4'b0001, 1'b0);
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_data = 4'b1111; req1_amt = 2'd2;
        #1;
        chk_rdy("abandon", 1'b0, 1'b0);
        tick();
        chk_rsp("abandon", 1'b1, 4'b0001, 1'b0);
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        chk("abandon_drain", rsp_valid, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_data  = 4'b0100; req1_amt = 2'd2;
        #1;
        chk_rdy("grant_after_abandon", 1'b0, 1'b1);
        tick();
        chk_rsp("grant_after_abandon", 1'b1, 4'b0001, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
